// File: rtl/spi_byte_xcvr_pkg.sv
// Shared definitions for the byte-wide SPI master: word width, counter
// widths and the transfer FSM state encoding.
package spi_byte_xcvr_pkg;

  localparam int BYTE_W = 8;
  // Wide enough to hold the value BYTE_W (count of completed bits).
  localparam int BITCNT_W = 4;
  // Divider counter width; covers HALF_PERIOD up to 255.
  localparam int DIV_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SCK_LOW  = 2'd1,
    ST_SCK_HIGH = 2'd2,
    ST_DONE     = 2'd3
  } xfer_state_e;

  // True while a byte is on the wire (divider running).
  function automatic logic in_transfer(xfer_state_e st);
    return (st == ST_SCK_LOW) || (st == ST_SCK_HIGH);
  endfunction

endpackage

// File: rtl/spi_byte_xcvr_clk_div.sv
// HALF_PERIOD tick generator. Counts clk cycles while enabled and pulses
// tick_o on the last cycle of each sclk half-period. The count is held at
// zero whenever the link is idle so every transfer starts phase-aligned to
// its accepting edge.
module spi_clk_divider
  import spi_byte_xcvr_pkg::*;
#(
  parameter int HALF_PERIOD = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(HALF_PERIOD - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  // Next count: restart at every tick and whenever disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || tick_o) cnt_d = '0;
    else                 cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_byte_xcvr.sv
// Byte-wide SPI master, mode 0, MSB first, full duplex. One accepted
// request produces exactly BYTE_W sclk pulses; miso is sampled on the clk
// edge that raises sclk and mosi changes on the edge that lowers it.
// cs after the byte follows the cs_at_end level captured with din, which
// lets a caller chain bytes into one chip-select frame.
module spi_byte_xcvr
  import spi_byte_xcvr_pkg::*;
#(
  parameter int HALF_PERIOD = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              send_request,
  input  logic [BYTE_W-1:0] din,
  input  logic              cs_at_end,
  input  logic              miso,
  output logic              mosi,
  output logic              sclk,
  output logic              cs,
  output logic [BYTE_W-1:0] dout,
  output logic              data_valid,
  output logic              processing,
  output logic [BITCNT_W-1:0] bit_counter
);

  xfer_state_e         state_q, state_d;
  logic [BYTE_W-1:0]   tx_sr_q, tx_sr_d;
  logic [BYTE_W-1:0]   rx_sr_q, rx_sr_d;
  logic                cs_end_q, cs_end_d;
  logic                mosi_q, mosi_d;
  logic                sclk_q, sclk_d;
  logic                cs_q, cs_d;
  logic [BYTE_W-1:0]   dout_q, dout_d;
  logic                dv_q, dv_d;
  logic                proc_q, proc_d;
  logic [BITCNT_W-1:0] bc_q, bc_d;
  logic [BITCNT_W-1:0] bc_inc;
  logic                tick;

  spi_clk_divider #(.HALF_PERIOD(HALF_PERIOD)) u_div (
    .clk   (clk),
    .reset (reset),
    .en_i  (in_transfer(state_q)),
    .tick_o(tick)
  );

  assign bc_inc = bc_q + 1'b1;

  // Next-state and output logic; every register holds unless a rule fires.
  always_comb begin
    state_d  = state_q;
    tx_sr_d  = tx_sr_q;
    rx_sr_d  = rx_sr_q;
    cs_end_d = cs_end_q;
    mosi_d   = mosi_q;
    sclk_d   = sclk_q;
    cs_d     = cs_q;
    dout_d   = dout_q;
    dv_d     = dv_q;
    proc_d   = proc_q;
    bc_d     = bc_q;

    case (state_q)
      // IDLE and DONE are identical: a finished byte may be followed
      // immediately by the next request.
      ST_IDLE, ST_DONE: begin
        sclk_d = 1'b0;
        if (send_request) begin
          tx_sr_d  = din;
          cs_end_d = cs_at_end;
          cs_d     = 1'b0;
          proc_d   = 1'b1;
          dv_d     = 1'b0;
          bc_d     = '0;
          mosi_d   = din[BYTE_W-1];
          state_d  = ST_SCK_LOW;
        end
      end

      ST_SCK_LOW: begin
        if (tick) begin
          sclk_d  = 1'b1;
          rx_sr_d = {rx_sr_q[BYTE_W-2:0], miso};
          state_d = ST_SCK_HIGH;
        end
      end

      ST_SCK_HIGH: begin
        if (tick) begin
          sclk_d = 1'b0;
          bc_d   = bc_inc;
          if (bc_inc < BITCNT_W'(BYTE_W)) begin
            tx_sr_d = {tx_sr_q[BYTE_W-2:0], 1'b0};
            mosi_d  = tx_sr_q[BYTE_W-2];
            state_d = ST_SCK_LOW;
          end else begin
            dout_d  = rx_sr_q;
            dv_d    = 1'b1;
            proc_d  = 1'b0;
            cs_d    = cs_end_q;
            mosi_d  = 1'b0;
            state_d = ST_DONE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset returns the bus to idle at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      tx_sr_q  <= '0;
      rx_sr_q  <= '0;
      cs_end_q <= 1'b1;
      mosi_q   <= 1'b0;
      sclk_q   <= 1'b0;
      cs_q     <= 1'b1;
      dout_q   <= '0;
      dv_q     <= 1'b0;
      proc_q   <= 1'b0;
      bc_q     <= '0;
    end else begin
      state_q  <= state_d;
      tx_sr_q  <= tx_sr_d;
      rx_sr_q  <= rx_sr_d;
      cs_end_q <= cs_end_d;
      mosi_q   <= mosi_d;
      sclk_q   <= sclk_d;
      cs_q     <= cs_d;
      dout_q   <= dout_d;
      dv_q     <= dv_d;
      proc_q   <= proc_d;
      bc_q     <= bc_d;
    end
  end

  assign mosi        = mosi_q;
  assign sclk        = sclk_q;
  assign cs          = cs_q;
  assign dout        = dout_q;
  assign data_valid  = dv_q;
  assign processing  = proc_q;
  assign bit_counter = bc_q;

endmodule

// File: tb/tb_spi_byte_xcvr.sv
// Bench for spi_byte_xcvr: one instance at HALF_PERIOD=1 and one at 3.
// A slave model shifts its byte out on sclk falls; a transaction-level
// reference predicts the captured mosi byte, dout, latency and cs level.
module tb_spi_byte_xcvr;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req1 = 1'b0, req3 = 1'b0;
  logic [7:0] din = 8'h00;
  logic cs_at_end = 1'b1;
  logic miso = 1'b0;
  logic sel = 1'b0;

  logic mosi1, sclk1, cs1, dv1, proc1;
  logic mosi3, sclk3, cs3, dv3, proc3;
  logic [7:0] dout1, dout3;
  logic [3:0] bc1, bc3;

  logic o_mosi, o_sclk, o_cs, o_dv, o_proc;
  logic [7:0] o_dout;
  logic [3:0] o_bc;

  int tests = 0;
  int fails = 0;
  logic model_cs [2];

  always #5 clk = ~clk;

  spi_byte_xcvr #(.HALF_PERIOD(1)) dut1 (
    .clk(clk), .reset(reset), .send_request(req1), .din(din),
    .cs_at_end(cs_at_end), .miso(miso), .mosi(mosi1), .sclk(sclk1),
    .cs(cs1), .dout(dout1), .data_valid(dv1), .processing(proc1),
    .bit_counter(bc1));

  spi_byte_xcvr #(.HALF_PERIOD(3)) dut3 (
    .clk(clk), .reset(reset), .send_request(req3), .din(din),
    .cs_at_end(cs_at_end), .miso(miso), .mosi(mosi3), .sclk(sclk3),
    .cs(cs3), .dout(dout3), .data_valid(dv3), .processing(proc3),
    .bit_counter(bc3));

  always_comb begin
    o_mosi = sel ? mosi3 : mosi1;
    o_sclk = sel ? sclk3 : sclk1;
    o_cs   = sel ? cs3   : cs1;
    o_dv   = sel ? dv3   : dv1;
    o_proc = sel ? proc3 : proc1;
    o_dout = sel ? dout3 : dout1;
    o_bc   = sel ? bc3   : bc1;
  end

  typedef struct {
    logic [7:0] din;
    logic       ce;
    logic [7:0] sb;
    int         hp;
    bit         inject;
    logic [7:0] exp_dout;
    logic [7:0] exp_mosi;
    int         exp_lat;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_mosi"}, int'(o_mosi), 0);
    check({nm, "_sclk"}, int'(o_sclk), 0);
    check({nm, "_cs"},   int'(o_cs),   1);
    check({nm, "_dout"}, int'(o_dout), 0);
    check({nm, "_dv"},   int'(o_dv),   0);
    check({nm, "_proc"}, int'(o_proc), 0);
    check({nm, "_bc"},   int'(o_bc),   0);
  endtask

  // One full transfer on the instance selected by hp, starting and ending
  // on a falling clk edge.
  task automatic do_xfer(input vec_t v, input string tag);
    logic [7:0] sh, cap;
    logic prev;
    int rises, hi, lat, early, cs_hi;
    sel = (v.hp == 3);
    #1;
    check({tag, "_cs_before"}, int'(o_cs), int'(model_cs[sel]));
    din = v.din; cs_at_end = v.ce; sh = v.sb; miso = sh[7];
    if (sel) req3 = 1'b1; else req1 = 1'b1;
    @(posedge clk); @(negedge clk);
    req1 = 1'b0; req3 = 1'b0;
    check({tag, "_k0_dv"},   int'(o_dv),   0);
    check({tag, "_k0_proc"}, int'(o_proc), 1);
    check({tag, "_k0_cs"},   int'(o_cs),   0);
    check({tag, "_k0_bc"},   int'(o_bc),   0);
    check({tag, "_k0_mosi"}, int'(o_mosi), int'(v.din[7]));
    prev = 1'b0; rises = 0; hi = 0; lat = -1; early = 0; cs_hi = 0; cap = 8'h00;
    for (int k = 1; k <= 16 * v.hp + 8 && lat < 0; k++) begin
      @(negedge clk);
      if (o_sclk && !prev) begin rises++; cap = {cap[6:0], o_mosi}; end
      if (!o_sclk && prev) begin sh = {sh[6:0], 1'b0}; miso = sh[7]; end
      if (o_sclk) hi++;
      if (o_dv) lat = k;
      else begin
        if (!o_proc) early++;
        if (o_cs) cs_hi++;
      end
      prev = o_sclk;
      if (v.inject) begin
        if (k == 3 || k == 9) begin din = 8'hFF; cs_at_end = ~v.ce; req1 = sel ? 1'b0 : 1'b1; req3 = sel; end
        else begin req1 = 1'b0; req3 = 1'b0; end
      end
    end
    req1 = 1'b0; req3 = 1'b0;
    check({tag, "_latency"},  lat, v.exp_lat);
    check({tag, "_rises"},    rises, 8);
    check({tag, "_mosi_seq"}, int'(cap), int'(v.exp_mosi));
    check({tag, "_hi_cyc"},   hi, 8 * v.hp);
    check({tag, "_early"},    early, 0);
    check({tag, "_cs_mid"},   cs_hi, 0);
    check({tag, "_dout"},     int'(o_dout), int'(v.exp_dout));
    check({tag, "_bc_end"},   int'(o_bc), 8);
    check({tag, "_proc_end"}, int'(o_proc), 0);
    check({tag, "_cs_end"},   int'(o_cs), int'(v.ce));
    check({tag, "_mosi_end"}, int'(o_mosi), 0);
    model_cs[sel] = v.ce;
  endtask

  // Transaction-level reference: the slave's byte comes back whole, the
  // master's byte goes out MSB first, and a byte costs 2*8 half-periods.
  function automatic vec_t model(input logic [7:0] d, input logic ce,
                                 input logic [7:0] sb, input int hp);
    vec_t r;
    r.din = d; r.ce = ce; r.sb = sb; r.hp = hp; r.inject = 1'b0;
    r.exp_dout = sb;
    r.exp_mosi = d;
    r.exp_lat  = 2 * 8 * hp;
    return r;
  endfunction

  initial begin
    int npos, pos0, pos1, bc_bad, r;
    tbl[0] = '{8'h03, 1'b1, 8'hA5, 1, 1'b0, 8'hA5, 8'h03, 16};
    tbl[1] = '{8'h00, 1'b0, 8'hFF, 1, 1'b0, 8'hFF, 8'h00, 16};
    tbl[2] = '{8'h55, 1'b1, 8'h00, 1, 1'b0, 8'h00, 8'h55, 16};
    tbl[3] = '{8'h3C, 1'b1, 8'h5A, 1, 1'b1, 8'h5A, 8'h3C, 16};
    tbl[4] = '{8'h81, 1'b1, 8'hC3, 3, 1'b0, 8'hC3, 8'h81, 48};
    tbl[5] = '{8'h7E, 1'b0, 8'h18, 3, 1'b0, 8'h18, 8'h7E, 48};
    model_cs[0] = 1'b1; model_cs[1] = 1'b1;

    // Reset state on both instances.
    repeat (3) @(negedge clk);
    sel = 1'b0; #1; check_reset_vals("rst1");
    sel = 1'b1; #1; check_reset_vals("rst3");
    reset = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) do_xfer(tbl[i], $sformatf("vec%0d", i));

    // Request held high: back-to-back bytes, one DONE cycle between them.
    sel = 1'b0; din = 8'h5A; cs_at_end = 1'b1; miso = 1'b0; req1 = 1'b1;
    @(posedge clk); @(negedge clk);
    npos = 0; pos0 = -1; pos1 = -1; bc_bad = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (k < 50 && o_dv) begin
        if (npos == 0) pos0 = k; else if (npos == 1) pos1 = k;
        npos++;
        if (o_bc != 4'd8) bc_bad++;
      end
      if (k == 34) req1 = 1'b0;
      if (k == 50) check("hold_dv_third", int'(o_dv), 1);
    end
    check("hold_npulse", npos, 2);
    check("hold_pos0", pos0, 16);
    check("hold_pos1", pos1, 33);
    check("hold_bc8", bc_bad, 0);
    model_cs[0] = 1'b1;

    // Reset mid-transfer after the third sclk rise.
    sel = 1'b0; din = 8'hF0; cs_at_end = 1'b1; req1 = 1'b1;
    @(posedge clk); @(negedge clk);
    req1 = 1'b0;
    r = 0;
    for (int k = 0; k < 20 && r < 3; k++) begin
      @(negedge clk);
      if (o_sclk && !sclk_prev_dummy(k)) r++;
    end
    check("midrst_rises", r, 3);
    check("midrst_sclk_pre", int'(o_sclk), 1);
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    reset = 1'b0;
    model_cs[0] = 1'b1; model_cs[1] = 1'b1;
    do_xfer(model(8'hC9, 1'b1, 8'h36, 1), "post_rst");

    // Randomized transfers against the reference.
    for (int i = 0; i < 12; i++) begin
      logic [7:0] d, s;
      logic c;
      int hp;
      d = 8'($urandom); s = 8'($urandom); c = 1'($urandom);
      hp = ($urandom_range(0, 2) == 0) ? 3 : 1;
      do_xfer(model(d, c, s, hp), $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // sclk as sampled on the previous falling edge, for rise detection in
  // the mid-transfer reset sequence.
  logic sclk_hist = 1'b0;
  always @(negedge clk) sclk_hist <= o_sclk;
  function automatic logic sclk_prev_dummy(input int k);
    return (k < 0) ? 1'b0 : sclk_hist;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_byte_xcvr.md
Name: spi_byte_xcvr

Overview:
- Byte-wide SPI master (mode 0, MSB first), full duplex: shifts one 8-bit word out on mosi while capturing 8 bits from miso.
- Instanced twice at top level:
  - EEPROM read channel, which sends instruction/address bytes and collects data bytes.
  - 74HC595 output channel, which streams pixel bytes.
- Request/handshake is a single-cycle request pulse, a busy flag and a level data-valid flag; the top-level FSM edge-detects data_valid.

Parameters:
- HALF_PERIOD, default 1: clk cycles per sclk half-period; legal range 1..255. sclk frequency = clk / (2*HALF_PERIOD).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- send_request  in  1  start a transfer; sampled only while processing=0.
- din  in  8  byte to transmit; captured when a request is accepted.
- cs_at_end  in  1  level cs takes after the transfer; captured with din.
- miso  in  1  serial data from slave.
- mosi  out  1  serial data to slave, MSB first.
- sclk  out  1  serial clock, idle low (CPOL=0).
- cs  out  1  chip select, active low.
- dout  out  8  last received byte.
- data_valid  out  1  level: dout holds a completed transfer.
- processing  out  1  transfer in progress (busy).
- bit_counter  out  4  bits completed in the current/last transfer, 0..8.

Behaviour:
- Reset values (asynchronous, immediate, also mid-transfer): mosi=0, sclk=0, cs=1, dout=0x00, data_valid=0, processing=0, bit_counter=0. Internal tx/rx shift registers are cleared, the divider counter is cleared, and the FSM is forced to IDLE.
- FSM states: IDLE, SCK_LOW, SCK_HIGH, DONE.
- IDLE:
  - sclk=0.
  - On an edge with send_request=1, accept the request:
    - tx_sr<=din, cs_end<=cs_at_end
    - cs<=0, processing<=1, data_valid<=0
    - bit_counter<=0, mosi<=din[7]
    - go to SCK_LOW.
  - Request accept is also permitted from DONE.
- SCK_LOW: hold for HALF_PERIOD cycles with sclk=0 and mosi stable, then:
  - sclk<=1
  - rx_sr<={rx_sr[6:0],miso}, so miso is sampled on the clk edge that raises sclk
  - go to SCK_HIGH.
- SCK_HIGH: hold for HALF_PERIOD cycles, then:
  - sclk<=0, bit_counter<=bit_counter+1.
  - If the incremented count <8: shift tx_sr left and drive mosi with the next bit, go to SCK_LOW.
  - Else go to DONE with the following on that same edge:
    - dout<=rx_sr (all 8 bits)
    - data_valid<=1, processing<=0
    - cs<=cs_end, mosi<=0.
- DONE behaves as IDLE. data_valid stays 1 until the next accepted request clears it.
- Latency with HALF_PERIOD=1:
  - Request sampled at edge E0.
  - sclk rises at E1,E3,...,E15 and falls at E2,...,E16.
  - data_valid=1 and processing=0 after E16, i.e. 16 cycles of transfer.
  - A request held high re-triggers at E17.
- send_request while processing=1 is ignored; din and cs_at_end changes mid-transfer have no effect.
- cs_at_end=0 keeps cs low across back-to-back transfers (multi-byte EEPROM frame). cs_at_end=1 releases cs high right after the byte.
- Only one sclk pulse train per request: exactly 8 rising edges. No clock glitches; sclk is a register output.
- miso has no effect outside SCK_LOW→SCK_HIGH sampling edges.

Decomposition:
- Shared package: the FSM state enum and the localparam BYTE_W=8. The top level reuses BYTE_W for the 595 and EEPROM paths.
- One natural sub-module: spi_clk_divider, the HALF_PERIOD tick generator. It may be inlined when HALF_PERIOD is fixed at 1.

Test Plan:
- Reset mid-transfer: assert reset after the 3rd sclk rise → all outputs return to reset values immediately. After release, a new request completes normally with bit_counter 0→8.
- din=0x03, cs_at_end=1, miso slave returns 0xA5 (changes on sclk fall), HALF_PERIOD=1 →
  - mosi sequence 0,0,0,0,0,0,1,1 at sclk rises
  - exactly 8 sclk pulses; dout=0xA5
  - data_valid rises 16 cycles after the request edge
  - cs low during the transfer, high afterwards.
- Two back-to-back transfers with cs_at_end=0 then 1 (din 0x00, 0x55; miso 0xFF then 0x00) → cs stays low across both and goes high only after the second. dout=0xFF then 0x00. data_valid clears on the second accept.
- send_request pulsed at cycles 3 and 9 of an active transfer, with din changed to 0xFF → ignored: transmitted byte unchanged, still 8 sclk pulses, processing never drops early.
- send_request held high continuously → transfers repeat with a one-cycle DONE gap. data_valid pulses high for 1 cycle per byte; bit_counter visible as 8 in that cycle.
- HALF_PERIOD=3, din=0x81 → sclk high/low phases 3 cycles each, completion after 48 cycles, mosi MSB=1 and LSB=1 correctly aligned.
